// File: rtl/pc_slice_pkg.sv
// Shared opcodes for the PC/LR datapath slice: PC and LR load-source selectors.
package pc_slice_pkg;

  typedef enum logic [1:0] {
    PcInc    = 2'd0,
    PcSysbus = 2'd1,
    PcAluOut = 2'd2,
    PcInt    = 2'd3
  } pc_select_t;

  typedef enum logic {
    LrSys = 1'b0,
    LrPc  = 1'b1
  } Lr_select_t;

endpackage

// File: rtl/pc_inc_cell.sv
// One half-adder stage of the PC incrementer ripple chain.
module pc_inc_cell (
  input  logic a,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ cin;
  assign cout = a & cin;

endmodule

// File: rtl/pc_slice.sv
// Program-counter / link-register slice: PC and LR registers, ripple incrementer,
// PC/LR source muxes and the tristate drive onto the shared system bus.
module pc_slice
  import pc_slice_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  inout  wire  [WIDTH-1:0] SysBus,
  output logic [WIDTH-1:0] Pc,
  output logic             PcIncCout,
  input  logic [WIDTH-1:0] ALU,
  input  logic             LrEn,
  input  Lr_select_t       LrSel,
  input  logic             LrWe,
  input  logic             PcEn,
  input  logic             PcIncCin,
  input  pc_select_t       PcSel,
  input  logic             PcWe,
  input  logic [WIDTH-1:0] PCI_Value,
  input  logic             Test
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_lr;
  logic [WIDTH-1:0] w_pc1;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_lr_next;
  // Unpacked so each carry is its own net; the chain never loops back on a vector.
  logic             w_carry [0:WIDTH];

  // Scan mode is handled outside the RTL; the pin exists only for the netlist.
  wire w_unused_test = Test;

  assign w_carry[0] = PcIncCin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_inc
    pc_inc_cell u_cell (
      .a    (r_pc[gi]),
      .cin  (w_carry[gi]),
      .sum  (w_pc1[gi]),
      .cout (w_carry[gi+1])
    );
  end

  assign PcIncCout = w_carry[WIDTH];
  assign Pc        = r_pc;

  always_comb begin
    w_pc_next = r_pc;
    unique case (PcSel)
      PcInc:    w_pc_next = w_pc1;
      PcSysbus: w_pc_next = SysBus;
      PcAluOut: w_pc_next = ALU;
      PcInt:    w_pc_next = PCI_Value;
      default:  w_pc_next = r_pc;
    endcase
  end

  always_comb begin
    w_lr_next = r_lr;
    unique case (LrSel)
      LrSys:   w_lr_next = SysBus;
      LrPc:    w_lr_next = w_pc1;
      default: w_lr_next = r_lr;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pc <= '0;
      r_lr <= '0;
    end else begin
      if (PcWe) r_pc <= w_pc_next;
      if (LrWe) r_lr <= w_lr_next;
    end
  end

  // PC wins if the controller ever asserts both enables.
  assign SysBus = PcEn ? r_pc : (LrEn ? r_lr : {WIDTH{1'bz}});

endmodule

// File: tb/tb_pc_slice.sv
// Bench for pc_slice: directed vector table, then random traffic against an arithmetic model.
module tb_pc_slice;
  import pc_slice_pkg::*;

  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic         Clock = 1'b0;
  logic         Reset;
  wire  [W-1:0] SysBus;
  logic [W-1:0] Pc;
  logic         PcIncCout;
  logic [W-1:0] ALU;
  logic         LrEn;
  Lr_select_t   LrSel;
  logic         LrWe;
  logic         PcEn;
  logic         PcIncCin;
  pc_select_t   PcSel;
  logic         PcWe;
  logic [W-1:0] PCI_Value;
  logic         Test;
  logic         drv_en;
  logic [W-1:0] drv_val;

  always #5 Clock = ~Clock;

  assign SysBus = drv_en ? drv_val : {W{1'bz}};

  pc_slice #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .SysBus    (SysBus),
    .Pc        (Pc),
    .PcIncCout (PcIncCout),
    .ALU       (ALU),
    .LrEn      (LrEn),
    .LrSel     (LrSel),
    .LrWe      (LrWe),
    .PcEn      (PcEn),
    .PcIncCin  (PcIncCin),
    .PcSel     (PcSel),
    .PcWe      (PcWe),
    .PCI_Value (PCI_Value),
    .Test      (Test)
  );

  int errors = 0;
  int checks = 0;
  int m_pc = 0;
  int m_lr = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       pcwe;
    pc_select_t pcsel;
    logic       lrwe;
    Lr_select_t lrsel;
    logic       cin;
    logic       pcen;
    logic       lren;
    logic       drven;
    logic [3:0] drv;
    logic [3:0] alu;
    logic [3:0] pci;
    logic       exp_cout;
    logic [3:0] exp_pc;
    logic [3:0] exp_lr;
  } vec_t;

  vec_t tbl [13];

  task automatic idle_inputs();
    Reset = 0; PcWe = 0; PcSel = PcInc; LrWe = 0; LrSel = LrSys; PcIncCin = 0;
    PcEn = 0; LrEn = 0; drv_en = 0; drv_val = '0; ALU = '0; PCI_Value = '0; Test = 0;
  endtask

  initial begin
    //            rst pcwe pcsel     lrwe lrsel cin pcen lren drven drv   alu   pci   cout pc    lr
    tbl[0]  = '{1'b0, 1'b1, PcInc,    1'b0, LrSys, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0};
    tbl[1]  = '{1'b0, 1'b1, PcInc,    1'b0, LrSys, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h1, 4'h0};
    tbl[2]  = '{1'b0, 1'b1, PcSysbus, 1'b0, LrSys, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 4'h0, 4'h0, 1'b0, 4'hA, 4'h0};
    tbl[3]  = '{1'b0, 1'b1, PcAluOut, 1'b0, LrSys, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 4'h5, 4'h9, 1'b0, 4'h5, 4'h0};
    tbl[4]  = '{1'b0, 1'b1, PcInt,    1'b0, LrSys, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 4'h5, 4'hF, 1'b0, 4'hF, 4'h0};
    tbl[5]  = '{1'b0, 1'b0, PcInc,    1'b1, LrSys, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 4'h0, 4'h0, 1'b0, 4'hF, 4'h3};
    tbl[6]  = '{1'b0, 1'b1, PcInc,    1'b1, LrPc,  1'b1, 1'b0, 1'b0, 1'b1, 4'h6, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0};
    tbl[7]  = '{1'b0, 1'b1, PcInt,    1'b1, LrPc,  1'b1, 1'b0, 1'b0, 1'b1, 4'h6, 4'h0, 4'h7, 1'b0, 4'h7, 4'h1};
    tbl[8]  = '{1'b0, 1'b0, PcSysbus, 1'b0, LrSys, 1'b1, 1'b0, 1'b0, 1'b1, 4'h9, 4'h2, 4'h2, 1'b0, 4'h7, 4'h1};
    tbl[9]  = '{1'b0, 1'b1, PcSysbus, 1'b1, LrSys, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h7, 4'h7};
    tbl[10] = '{1'b0, 1'b1, PcAluOut, 1'b0, LrSys, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'hC, 4'h0, 1'b0, 4'hC, 4'h7};
    tbl[11] = '{1'b0, 1'b1, PcSysbus, 1'b1, LrPc,  1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h7, 4'hD};
    tbl[12] = '{1'b1, 1'b1, PcInt,    1'b1, LrSys, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0};

    idle_inputs();
    Reset = 1; PcWe = 1; LrWe = 1;
    repeat (2) @(posedge Clock);
    #1;
    idle_inputs();
    PcEn = 1;
    #1;
    chk("reset_pc", Pc, 4'h0);
    chk("reset_bus_pc", SysBus, 4'h0);
    PcEn = 0; LrEn = 1;
    #1;
    chk("reset_bus_lr", SysBus, 4'h0);
    m_pc = 0; m_lr = 0;

    for (int i = 0; i < 13; i++) begin
      @(negedge Clock);
      Reset = tbl[i].rst; PcWe = tbl[i].pcwe; PcSel = tbl[i].pcsel; LrWe = tbl[i].lrwe;
      LrSel = tbl[i].lrsel; PcIncCin = tbl[i].cin; PcEn = tbl[i].pcen; LrEn = tbl[i].lren;
      drv_en = tbl[i].drven; drv_val = tbl[i].drv; ALU = tbl[i].alu; PCI_Value = tbl[i].pci;
      #1;
      chk($sformatf("vec%0d_cout", i), {3'b0, PcIncCout}, {3'b0, tbl[i].exp_cout});
      if (tbl[i].pcen) chk($sformatf("vec%0d_bus_pc", i), SysBus, m_pc[W-1:0]);
      else if (tbl[i].lren) chk($sformatf("vec%0d_bus_lr", i), SysBus, m_lr[W-1:0]);
      @(posedge Clock);
      #1;
      idle_inputs();
      chk($sformatf("vec%0d_pc", i), Pc, tbl[i].exp_pc);
      LrEn = 1;
      #1;
      chk($sformatf("vec%0d_lr", i), SysBus, tbl[i].exp_lr);
      LrEn = 0; PcEn = 1;
      #1;
      chk($sformatf("vec%0d_bus_pc_after", i), SysBus, tbl[i].exp_pc);
      m_pc = int'(tbl[i].exp_pc);
      m_lr = int'(tbl[i].exp_lr);
    end

    // Both enables at once: PC must own the bus.
    @(negedge Clock);
    idle_inputs();
    PcWe = 1; PcSel = PcInt; PCI_Value = 4'hB; LrWe = 1; LrSel = LrSys; drv_en = 1; drv_val = 4'h4;
    @(posedge Clock);
    #1;
    idle_inputs();
    PcEn = 1; LrEn = 1;
    #1;
    chk("priority_bus", SysBus, 4'hB);
    m_pc = 'hB; m_lr = 'h4;

    // Random traffic against an arithmetic model of the PC/LR behaviour.
    for (int n = 0; n < 400; n++) begin
      int sum, nxt_pc, nxt_lr, bus;
      @(negedge Clock);
      idle_inputs();
      Reset = ($urandom_range(0, 24) == 0);
      PcWe = 1'($urandom_range(0, 1));
      PcSel = pc_select_t'($urandom_range(0, 3));
      LrWe = 1'($urandom_range(0, 1));
      LrSel = Lr_select_t'($urandom_range(0, 1));
      PcIncCin = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: PcEn = 1;
        1: LrEn = 1;
        default: drv_en = 1;
      endcase
      drv_val = W'($urandom);
      ALU = W'($urandom);
      PCI_Value = W'($urandom);
      #1;
      sum = m_pc + int'(PcIncCin);
      bus = PcEn ? m_pc : (LrEn ? m_lr : int'(drv_val));
      chk("rnd_cout", {3'b0, PcIncCout}, (sum > MASK) ? 4'h1 : 4'h0);
      if (PcEn) chk("rnd_bus_pc", SysBus, m_pc[W-1:0]);
      if (LrEn) chk("rnd_bus_lr", SysBus, m_lr[W-1:0]);
      nxt_pc = m_pc;
      nxt_lr = m_lr;
      if (PcWe) begin
        case (PcSel)
          PcInc:    nxt_pc = sum % (MASK + 1);
          PcSysbus: nxt_pc = bus;
          PcAluOut: nxt_pc = int'(ALU);
          default:  nxt_pc = int'(PCI_Value);
        endcase
      end
      if (LrWe) nxt_lr = (LrSel == LrPc) ? sum % (MASK + 1) : bus;
      if (Reset) begin
        nxt_pc = 0;
        nxt_lr = 0;
      end
      @(posedge Clock);
      #1;
      m_pc = nxt_pc;
      m_lr = nxt_lr;
      chk("rnd_pc", Pc, m_pc[W-1:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
